// File: rtl/proc_n.sv
// proc_n - parametrised multicycle processor core.
//
// Eight W-bit general registers (R0-R7), A and G accumulator registers and a
// shared bus. One instruction is executed per Run pulse sampled in T0; Done is
// high during the final step of each instruction.
//
// Parameters:
//   W         data/register width, must be >= 9 (instruction is DIN[W-1:W-9])
//
// Ports:
//   Clock     single clock, all state updates on the rising edge
//   Reset     synchronous, active-high reset
//   Run       start request, sampled only in T0
//   DIN       instruction word in T0, immediate operand in T1 for mvi
//   Done      combinational, high during the final step of an instruction
//   BusWires  current bus value (0 when no source drives it)
//   Zero      registered flag, high when the last G write was 0
//
// Build option:
//   PROC_N_LOGIC_EN  when defined, opcodes 100 (and) and 101 (xor) execute;
//                    otherwise they decode as NOPs and the logic datapath is
//                    not built.
//
// Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 xor, 110 mvnz,
//          111 reserved (NOP).
//
// state | meaning
// ------+------------------------------------------------------------
// T0    | idle / fetch: IR <- DIN when Run=1
// T1    | mv/mvi/mvnz/NOP complete here; ALU ops load A from Rx
// T2    | ALU ops: G <- A op Ry, Zero updated
// T3    | ALU ops: Rx <- G, Done

module proc_n #(
  parameter int W = 9
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  output logic         Done,
  output logic [W-1:0] BusWires,
  output logic         Zero
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_RX   = 3'd1;
  localparam logic [2:0] SEL_RY   = 3'd2;
  localparam logic [2:0] SEL_DIN  = 3'd3;
  localparam logic [2:0] SEL_G    = 3'd4;

  logic [1:0]   state, state_nxt;
  logic [8:0]   ir;
  logic [W-1:0] r [8];
  logic [W-1:0] a, g;
  logic [W-1:0] alu_res;
  logic [W-1:0] rx_val, ry_val;
  logic [2:0]   op, rx, ry;
  logic [7:0]   xsel, ysel;
  logic [7:0]   rin;
  logic         ain, gin;
  logic         is_alu;
  logic [2:0]   bus_sel;

  assign op   = ir[8:6];
  assign rx   = ir[5:3];
  assign ry   = ir[2:0];
  assign xsel = 8'b0000_0001 << rx;
  assign ysel = 8'b0000_0001 << ry;

  // One-hot AND-OR register read ports.
  always_comb begin
    rx_val = '0;
    ry_val = '0;
    for (int k = 0; k < 8; k++) begin
      if (xsel[k]) rx_val = rx_val | r[k];
      if (ysel[k]) ry_val = ry_val | r[k];
    end
  end

  // Without the logic option, and/xor fall through to the NOP decode.
  always_comb begin
    case (op)
      OP_ADD, OP_SUB: is_alu = 1'b1;
`ifdef PROC_N_LOGIC_EN
      OP_AND, OP_XOR: is_alu = 1'b1;
`endif
      default:        is_alu = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_SUB:  alu_res = a - BusWires;
`ifdef PROC_N_LOGIC_EN
      OP_AND:  alu_res = a & BusWires;
      OP_XOR:  alu_res = a ^ BusWires;
`endif
      default: alu_res = a + BusWires;
    endcase
  end

  always_comb begin
    Done      = 1'b0;
    rin       = 8'h00;
    ain       = 1'b0;
    gin       = 1'b0;
    bus_sel   = SEL_NONE;
    state_nxt = state;
    case (state)
      T0: begin
        if (Run) state_nxt = T1;
      end
      T1: begin
        if (is_alu) begin
          bus_sel   = SEL_RX;
          ain       = 1'b1;
          state_nxt = T2;
        end else begin
          Done      = 1'b1;
          state_nxt = T0;
          case (op)
            OP_MV: begin
              bus_sel = SEL_RY;
              rin     = xsel;
            end
            OP_MVI: begin
              bus_sel = SEL_DIN;
              rin     = xsel;
            end
            OP_MVNZ: begin
              bus_sel = SEL_RY;
              rin     = Zero ? 8'h00 : xsel;
            end
            default: ;
          endcase
        end
      end
      T2: begin
        bus_sel   = SEL_RY;
        gin       = 1'b1;
        state_nxt = T3;
      end
      default: begin
        bus_sel   = SEL_G;
        rin       = xsel;
        Done      = 1'b1;
        state_nxt = T0;
      end
    endcase
  end

  always_comb begin
    case (bus_sel)
      SEL_RX:  BusWires = rx_val;
      SEL_RY:  BusWires = ry_val;
      SEL_DIN: BusWires = DIN;
      SEL_G:   BusWires = g;
      default: BusWires = '0;
    endcase
  end

  // Reset takes priority over every load, so an aborted instruction never
  // leaves a partial register write behind.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
      Zero  <= 1'b0;
      for (int k = 0; k < 8; k++) r[k] <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && Run) ir <= DIN[W-1:W-9];
      if (ain) a <= BusWires;
      if (gin) begin
        g    <= alu_res;
        Zero <= (alu_res == '0);
      end
      for (int k = 0; k < 8; k++) begin
        if (rin[k]) r[k] <= BusWires;
      end
    end
  end

endmodule

// File: tb/tb_proc_n.sv
// Testbench for proc_n (W=9). Each instruction's expected bus value at Done
// and its latency are computed from a small ISA model and pushed onto a
// scoreboard queue when the instruction is issued; they are popped and
// compared when the DUT raises Done. Registers are observed through the bus
// by issuing mv Rk,Rk.

module tb_proc_n;

  logic       Clock;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic       Done;
  logic [8:0] BusWires;
  logic       Zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [8:0] m_r [8];
  logic       m_zero;
  logic [8:0] q_bus [$];
  int         q_lat [$];

  proc_n #(.W(9)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Run      (Run),
    .DIN      (DIN),
    .Done     (Done),
    .BusWires (BusWires),
    .Zero     (Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Precondition: called #1 after a rising edge with the FSM in T0.
  task automatic exec(input logic [2:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic [8:0] imm,
                      input bit hold, output logic [8:0] obs);
    logic [8:0] eb;
    logic [8:0] res;
    logic [8:0] pb;
    int         el, pl, cyc;
    bit         alu, seen;
    alu = 1'b0;
    res = '0;
    eb  = '0;
    el  = 2;
    case (op)
      3'b000: begin eb = m_r[y]; m_r[x] = m_r[y]; end
      3'b001: begin eb = imm; m_r[x] = imm; end
      3'b010: begin res = m_r[x] + m_r[y]; alu = 1'b1; end
      3'b011: begin res = m_r[x] - m_r[y]; alu = 1'b1; end
`ifdef PROC_N_LOGIC_EN
      3'b100: begin res = m_r[x] & m_r[y]; alu = 1'b1; end
      3'b101: begin res = m_r[x] ^ m_r[y]; alu = 1'b1; end
`endif
      3'b110: begin eb = m_r[y]; if (!m_zero) m_r[x] = m_r[y]; end
      default: eb = '0;
    endcase
    if (alu) begin
      eb     = res;
      el     = 4;
      m_r[x] = res;
      m_zero = (res == '0);
    end
    q_bus.push_back(eb);
    q_lat.push_back(el);

    Run = 1'b1;
    DIN = {op, x, y};
    @(negedge Clock);
    total_cnt++;
    if (Done !== 1'b0 || BusWires !== 9'h000)
      $display("FAIL t0_idle op=%0d: Done=%b BusWires=%h, required Done=0 BusWires=000",
               op, Done, BusWires);
    else pass_cnt++;
    @(posedge Clock); #1;
    DIN = imm;
    if (!hold) Run = 1'b0;
    cyc  = 2;
    seen = 1'b0;
    obs  = 'x;
    while (!seen && cyc <= 6) begin
      @(negedge Clock);
      if (Done === 1'b1) begin
        seen = 1'b1;
        obs  = BusWires;
      end
      @(posedge Clock); #1;
      if (!seen) begin
        cyc++;
        // Both are don't-cares outside T0/T1.
        DIN = 9'($urandom);
        Run = hold ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    if (!hold) Run = 1'b0;

    pb = q_bus.pop_front();
    pl = q_lat.pop_front();
    total_cnt++;
    if (!seen)
      $display("FAIL latency op=%0d: no Done within budget, required Done at cycle %0d", op, pl);
    else if (cyc != pl)
      $display("FAIL latency op=%0d: Done at cycle %0d, required cycle %0d", op, cyc, pl);
    else pass_cnt++;
    total_cnt++;
    if (obs !== pb)
      $display("FAIL done_bus op=%0d x=%0d y=%0d: BusWires=%h, required %h", op, x, y, obs, pb);
    else pass_cnt++;
    total_cnt++;
    if (Zero !== m_zero)
      $display("FAIL zero_flag op=%0d: Zero=%b, required %b", op, Zero, m_zero);
    else pass_cnt++;
  endtask

  task automatic read_reg(input logic [2:0] k, input logic [8:0] expv);
    logic [8:0] obs;
    exec(3'b000, k, k, 9'h000, 1'b0, obs);
    total_cnt++;
    if (obs !== expv) $display("FAIL read_r%0d: value=%h, required %h", k, obs, expv);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = '0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    total_cnt++;
    if (Done !== 1'b0 || BusWires !== 9'h000 || Zero !== 1'b0)
      $display("FAIL reset_outputs: Done=%b BusWires=%h Zero=%b, required 0/000/0",
               Done, BusWires, Zero);
    else pass_cnt++;
    @(posedge Clock); #1;
    for (int k = 0; k < 8; k++) m_r[k] = '0;
    m_zero = 1'b0;
    for (int k = 0; k < 8; k++) read_reg(3'(k), 9'h000);
  endtask

  task automatic test_mvi();
    logic [8:0] obs;
    exec(3'b001, 3'd0, 3'd0, 9'h005, 1'b0, obs);
    total_cnt++;
    if (obs !== 9'h005) $display("FAIL mvi_bus: BusWires=%h, required 005", obs);
    else pass_cnt++;
    read_reg(3'd0, 9'h005);
  endtask

  task automatic test_add();
    logic [8:0] obs;
    exec(3'b001, 3'd1, 3'd0, 9'h003, 1'b0, obs);
    exec(3'b010, 3'd0, 3'd1, 9'h000, 1'b0, obs);
    total_cnt++;
    if (obs !== 9'h008) $display("FAIL add_bus: BusWires=%h, required 008", obs);
    else pass_cnt++;
    read_reg(3'd0, 9'h008);
    total_cnt++;
    if (Zero !== 1'b0) $display("FAIL add_zero: Zero=%b, required 0", Zero);
    else pass_cnt++;
  endtask

  task automatic test_sub_mvnz();
    logic [8:0] obs;
    exec(3'b001, 3'd2, 3'd0, 9'h002, 1'b0, obs);
    exec(3'b001, 3'd3, 3'd0, 9'h003, 1'b0, obs);
    exec(3'b001, 3'd5, 3'd0, 9'h0AA, 1'b0, obs);
    exec(3'b011, 3'd2, 3'd3, 9'h000, 1'b0, obs);
    read_reg(3'd2, 9'h1FF);
    total_cnt++;
    if (Zero !== 1'b0) $display("FAIL sub_wrap_zero: Zero=%b, required 0", Zero);
    else pass_cnt++;
    exec(3'b110, 3'd4, 3'd2, 9'h000, 1'b0, obs);
    read_reg(3'd4, 9'h1FF);
    exec(3'b011, 3'd2, 3'd2, 9'h000, 1'b0, obs);
    read_reg(3'd2, 9'h000);
    total_cnt++;
    if (Zero !== 1'b1) $display("FAIL sub_self_zero: Zero=%b, required 1", Zero);
    else pass_cnt++;
    exec(3'b110, 3'd5, 3'd2, 9'h000, 1'b0, obs);
    read_reg(3'd5, 9'h0AA);
  endtask

  task automatic test_same_reg();
    logic [8:0] obs;
    exec(3'b001, 3'd1, 3'd0, 9'h0C3, 1'b0, obs);
    exec(3'b010, 3'd1, 3'd1, 9'h000, 1'b0, obs);
    read_reg(3'd1, 9'h186);
  endtask

  task automatic test_logic();
    logic [8:0] obs;
    exec(3'b001, 3'd6, 3'd0, 9'h1F0, 1'b0, obs);
    exec(3'b001, 3'd7, 3'd0, 9'h0FF, 1'b0, obs);
    exec(3'b010, 3'd1, 3'd1, 9'h000, 1'b0, obs);  // Zero known 0
    exec(3'b100, 3'd6, 3'd7, 9'h000, 1'b0, obs);
`ifdef PROC_N_LOGIC_EN
    read_reg(3'd6, 9'h0F0);
`else
    read_reg(3'd6, 9'h1F0);
`endif
    exec(3'b101, 3'd6, 3'd6, 9'h000, 1'b0, obs);
`ifdef PROC_N_LOGIC_EN
    read_reg(3'd6, 9'h000);
    total_cnt++;
    if (Zero !== 1'b1) $display("FAIL xor_zero: Zero=%b, required 1", Zero);
    else pass_cnt++;
`else
    read_reg(3'd6, 9'h1F0);
    total_cnt++;
    if (Zero !== 1'b0) $display("FAIL xor_nop_zero: Zero=%b, required 0", Zero);
    else pass_cnt++;
`endif
    exec(3'b111, 3'd6, 3'd7, 9'h000, 1'b0, obs);
    read_reg(3'd6, m_r[6]);
  endtask

  task automatic test_mid_reset();
    logic [8:0] obs;
    exec(3'b011, 3'd2, 3'd2, 9'h000, 1'b0, obs);  // Zero=1
    exec(3'b001, 3'd0, 3'd0, 9'h1FB, 1'b0, obs);
    exec(3'b001, 3'd1, 3'd0, 9'h005, 1'b0, obs);
    // add R0,R1 would give 0 and keep Zero=1 if the T2 edge were not aborted.
    Run = 1'b1;
    DIN = 9'b010_000_001;
    @(posedge Clock); #1;
    Run = 1'b0;
    DIN = '0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    total_cnt++;
    if (Done !== 1'b0) $display("FAIL mid_reset_t2_done: Done=%b, required 0", Done);
    else pass_cnt++;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    total_cnt++;
    if (Done !== 1'b0 || BusWires !== 9'h000 || Zero !== 1'b0)
      $display("FAIL mid_reset_outputs: Done=%b BusWires=%h Zero=%b, required 0/000/0",
               Done, BusWires, Zero);
    else pass_cnt++;
    @(posedge Clock); #1;
    for (int k = 0; k < 8; k++) m_r[k] = '0;
    m_zero = 1'b0;
    read_reg(3'd0, 9'h000);
    read_reg(3'd1, 9'h000);
  endtask

  task automatic test_back_to_back();
    logic [8:0] obs;
    exec(3'b001, 3'd3, 3'd0, 9'h055, 1'b1, obs);
    exec(3'b001, 3'd4, 3'd0, 9'h0AA, 1'b1, obs);
    exec(3'b010, 3'd3, 3'd4, 9'h000, 1'b1, obs);
    exec(3'b000, 3'd5, 3'd3, 9'h000, 1'b0, obs);
    read_reg(3'd5, 9'h0FF);
  endtask

  task automatic test_random();
    logic [8:0] obs;
    for (int i = 0; i < 30; i++)
      exec(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 9'($urandom), 1'($urandom_range(0, 1)), obs);
    Run = 1'b0;
    for (int k = 0; k < 8; k++) read_reg(3'(k), m_r[k]);
  endtask

  initial begin
    Reset  = 1'b1;
    Run    = 1'b0;
    DIN    = '0;
    m_zero = 1'b0;
    for (int k = 0; k < 8; k++) m_r[k] = '0;
    test_reset();
    test_mvi();
    test_add();
    test_sub_mvnz();
    test_same_reg();
    test_logic();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
